// File: rtl/seg_hex_pkg.sv
// Shared constants for the two-digit seven-segment hex display driver.
// Segment patterns are {dp,g,f,e,d,c,b,a}, active-low.
package seg_hex_pkg;

    localparam logic [7:0] SEG_BLANK = 8'hFF;
    localparam logic [1:0] EN_LO     = 2'b01;
    localparam logic [1:0] EN_HI     = 2'b10;
    localparam logic [1:0] EN_OFF    = 2'b00;

    typedef enum logic {
        DIG_LO = 1'b0,
        DIG_HI = 1'b1
    } digit_e;

    // Index n holds the glyph for nibble n; dp is always off.
    localparam logic [15:0][7:0] HEX_FONT = {
        8'h8E, 8'h86, 8'hA1, 8'hC6,
        8'h83, 8'h88, 8'h90, 8'h80,
        8'hF8, 8'h82, 8'h92, 8'h99,
        8'hB0, 8'hA4, 8'hF9, 8'hC0
    };

endpackage

// File: rtl/seg_hex_driver_rom.sv
// Combinational nibble-to-segment lookup for the hex display.
module hex_seg_rom
    import seg_hex_pkg::*;
(
    input  logic [3:0] nib,
    output logic [7:0] seg
);

    always_comb begin
        seg = HEX_FONT[nib];
    end

endmodule

// File: rtl/seg_hex_driver.sv
// Bit-rate enable generator plus two-digit multiplexed hex display driver.
// Optional macro SEG_HEX_LEADING_BLANK_EN blanks the high digit when it is 0.
module seg_hex_driver
    import seg_hex_pkg::*;
#(
    parameter int unsigned BIT_DIV  = 5208,
    parameter int unsigned SCAN_DIV = 50000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] data_in,
    output logic       bit_tick,
    output logic [7:0] hexcode,
    output logic [1:0] en
);

    localparam int unsigned BW = (BIT_DIV  > 1) ? $clog2(BIT_DIV)  : 1;
    localparam int unsigned SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [BW-1:0] BIT_LAST  = BW'(BIT_DIV - 1);
    localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_DIV - 1);

    logic [BW-1:0] bit_cnt_q, bit_cnt_d;
    logic          bit_tick_q, bit_tick_d;
    logic [SW-1:0] scan_cnt_q, scan_cnt_d;
    digit_e        sel_q, sel_d;

    logic [3:0]    nib_s1_q, nib_s1_d;
    digit_e        sel_s1_q, sel_s1_d;
    logic          v_s1_q, v_s1_d;

    logic [7:0]    hexcode_q, hexcode_d;
    logic [1:0]    en_q, en_d;
    logic [7:0]    rom_seg;

`ifdef SEG_HEX_LEADING_BLANK_EN
    logic          blank_s1_q, blank_s1_d;
`endif

    always_comb begin
        bit_cnt_d  = (bit_cnt_q == BIT_LAST) ? '0 : bit_cnt_q + BW'(1);
        bit_tick_d = (bit_cnt_q == BIT_LAST);
        scan_cnt_d = (scan_cnt_q == SCAN_LAST) ? '0 : scan_cnt_q + SW'(1);
        sel_d      = sel_q;
        if (scan_cnt_q == SCAN_LAST) begin
            sel_d = (sel_q == DIG_LO) ? DIG_HI : DIG_LO;
        end
    end

    // Stage 1: pick the nibble for the digit currently being scanned.
    always_comb begin
        nib_s1_d = (sel_q == DIG_HI) ? data_in[7:4] : data_in[3:0];
        sel_s1_d = sel_q;
        v_s1_d   = 1'b1;
`ifdef SEG_HEX_LEADING_BLANK_EN
        blank_s1_d = (sel_q == DIG_HI) && (data_in[7:4] == 4'h0);
`endif
    end

    hex_seg_rom u_rom (
        .nib (nib_s1_q),
        .seg (rom_seg)
    );

    // Stage 2: the valid flag keeps the outputs dark until stage 1 has real data.
    always_comb begin
        hexcode_d = SEG_BLANK;
        en_d      = EN_OFF;
        if (v_s1_q) begin
            hexcode_d = rom_seg;
            en_d      = (sel_s1_q == DIG_HI) ? EN_HI : EN_LO;
`ifdef SEG_HEX_LEADING_BLANK_EN
            if (blank_s1_q) begin
                hexcode_d = SEG_BLANK;
            end
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt_q  <= '0;
            bit_tick_q <= 1'b0;
            scan_cnt_q <= '0;
            sel_q      <= DIG_LO;
            nib_s1_q   <= '0;
            sel_s1_q   <= DIG_LO;
            v_s1_q     <= 1'b0;
            hexcode_q  <= SEG_BLANK;
            en_q       <= EN_OFF;
        end else begin
            bit_cnt_q  <= bit_cnt_d;
            bit_tick_q <= bit_tick_d;
            scan_cnt_q <= scan_cnt_d;
            sel_q      <= sel_d;
            nib_s1_q   <= nib_s1_d;
            sel_s1_q   <= sel_s1_d;
            v_s1_q     <= v_s1_d;
            hexcode_q  <= hexcode_d;
            en_q       <= en_d;
        end
    end

`ifdef SEG_HEX_LEADING_BLANK_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blank_s1_q <= 1'b0;
        end else begin
            blank_s1_q <= blank_s1_d;
        end
    end
`endif

    assign bit_tick = bit_tick_q;
    assign hexcode  = hexcode_q;
    assign en       = en_q;

endmodule

// File: tb/tb_seg_hex_driver.sv
// Self-checking bench for seg_hex_driver with small divider values.
module tb_seg_hex_driver;

    localparam int BITD  = 4;
    localparam int SCAND = 3;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] data_in = 8'h00;
    logic       bit_tick;
    logic [7:0] hexcode;
    logic [1:0] en;

    int vectors = 0;
    int miscompares = 0;

    // k = number of rising edges since the last reset release.
    int k = 0;
    logic [7:0] dat [0:4095];
    logic [7:0] font [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                              8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

    seg_hex_driver #(.BIT_DIV(BITD), .SCAN_DIV(SCAND)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .data_in  (data_in),
        .bit_tick (bit_tick),
        .hexcode  (hexcode),
        .en       (en)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s k=%0d observed=%h expected=%h", tag, k, got, exp);
        end
    endtask

    // Reference: digit dwells SCAND edges, pipeline is two edges deep.
    task automatic check_now();
        logic       tick;
        logic [1:0] e;
        logic [7:0] h;
        logic [7:0] d;
        int         s;
        tick = (k > 0) && (k % BITD == 0);
        e = 2'b00;
        h = 8'hFF;
        if (k >= 2) begin
            s = ((k - 2) / SCAND) % 2;
            d = dat[k - 1];
            e = (s == 1) ? 2'b10 : 2'b01;
            h = (s == 1) ? font[d[7:4]] : font[d[3:0]];
`ifdef SEG_HEX_LEADING_BLANK_EN
            if (s == 1 && d[7:4] == 4'h0) h = 8'hFF;
`endif
        end
        chk("bit_tick", {7'd0, bit_tick}, {7'd0, tick});
        chk("en", {6'd0, en}, {6'd0, e});
        chk("hexcode", hexcode, h);
    endtask

    task automatic cycle(input logic [7:0] next_data);
        @(posedge clk);
        k++;
        #1;
        data_in = next_data;
        dat[k + 1] = next_data;
        @(negedge clk);
        check_now();
    endtask

    task automatic release_reset(input logic [7:0] d);
        @(negedge clk);
        data_in = d;
        k = 0;
        dat[1] = d;
        rst_n = 1'b1;
    endtask

    task automatic hold(input logic [7:0] d, input int n);
        for (int i = 0; i < n; i++) cycle(d);
    endtask

    initial begin
        logic [7:0] r;
        @(negedge clk);
        chk("rst_bit_tick", {7'd0, bit_tick}, 8'h00);
        chk("rst_en", {6'd0, en}, 8'h00);
        chk("rst_hexcode", hexcode, 8'hFF);

        // Scan alternation and bit_tick cadence
        release_reset(8'h3A);
        hold(8'h3A, 14);

        // Low-digit value 5, high digit zero (leading-blank case)
        hold(8'h05, 8);

        // Full font sweep; each value held for a whole frame so both digits show
        for (int n = 0; n < 16; n++) begin
            r = 8'($urandom_range(255));
            r[3:0] = 4'(n);
            hold(r, 2 * SCAND);
        end
        for (int n = 0; n < 16; n++) hold({4'(n), 4'(15 - n)}, 2 * SCAND);

        // Random data changes, including mid-dwell
        for (int i = 0; i < 80; i++) begin
            if ($urandom_range(1) == 1) r = 8'($urandom_range(255));
            cycle(r);
        end

        // Asynchronous reset mid-dwell
        hold(8'hC7, 4);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_bit_tick", {7'd0, bit_tick}, 8'h00);
        chk("async_en", {6'd0, en}, 8'h00);
        chk("async_hexcode", hexcode, 8'hFF);
        @(negedge clk);
        chk("held_en", {6'd0, en}, 8'h00);
        chk("held_hexcode", hexcode, 8'hFF);

        // Restart must replay the first run
        release_reset(8'h3A);
        hold(8'h3A, 14);
        hold(8'h05, 8);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
